// File: rtl/overlap_accum_seq.sv
// overlap_accum_seq: sequential overlap-accumulate stage for Karatsuba GF(2)
// multipliers. NUM partial products of PW bits arrive one per handshake. Each
// one is XOR-folded into an OW-bit accumulator at a stride of SHIFT bits, and
// the recombined word is then offered on a valid/ready output port.
module overlap_accum_seq #(
   parameter  int PW        = 15,
   parameter  int SHIFT     = 8,
   parameter  int NUM       = 3,
   parameter  int MSB_FIRST = 0,
   localparam int OW        = (NUM - 1) * SHIFT + PW,
   localparam int CW        = $clog2(NUM)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic [CW-1:0] in_idx
);

   localparam logic [0:0] ST_ACC = 1'b0;
   localparam logic [0:0] ST_OUT = 1'b1;

   // Place a partial product at its slot offset. Slot order is ascending by
   // default and descending when MSB_FIRST is set. Zero-extending before the
   // shift keeps every bit inside [0, OW-1].
   function automatic logic [OW-1:0] place(input logic [PW-1:0] d,
                                           input logic [CW-1:0] k);
      logic [OW-1:0] ext;
      int            slot;
      ext  = {{(OW-PW){1'b0}}, d};
      slot = (MSB_FIRST != 0) ? (NUM - 1 - int'(k)) : int'(k);
      return ext << (slot * SHIFT);
   endfunction

   logic [0:0]    state_r;
   logic [0:0]    state_nxt_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic [OW-1:0] acc_r;
   logic [OW-1:0] acc_nxt_s;
   logic [OW-1:0] placed_s;
   logic          last_s;
   logic          in_ready_r;
   logic          out_valid_r;

   assign placed_s = place(in_data, cnt_r);
   assign last_s   = (cnt_r == CW'(NUM - 1));

   // Next-state logic: flush wins over any handshake; the first product of a
   // result overwrites the stale accumulator instead of needing a clear cycle.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      acc_nxt_s   = acc_r;
      if (flush) begin
         state_nxt_s = ST_ACC;
         cnt_nxt_s   = {CW{1'b0}};
         acc_nxt_s   = {OW{1'b0}};
      end else begin
         case (state_r)
            ST_ACC: begin
               if (in_valid) begin
                  if (cnt_r == {CW{1'b0}}) begin
                     acc_nxt_s = placed_s;
                  end else begin
                     acc_nxt_s = acc_r ^ placed_s;
                  end
                  if (last_s) begin
                     cnt_nxt_s   = {CW{1'b0}};
                     state_nxt_s = ST_OUT;
                  end else begin
                     cnt_nxt_s   = cnt_r + CW'(1);
                     state_nxt_s = ST_ACC;
                  end
               end else begin
                  state_nxt_s = ST_ACC;
                  cnt_nxt_s   = cnt_r;
                  acc_nxt_s   = acc_r;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  state_nxt_s = ST_ACC;
               end else begin
                  state_nxt_s = ST_OUT;
               end
            end
            default: begin
               state_nxt_s = ST_ACC;
               cnt_nxt_s   = {CW{1'b0}};
               acc_nxt_s   = {OW{1'b0}};
            end
         endcase
      end
   end

   // State, counter, accumulator and handshake flags, all async-cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_ACC;
         cnt_r       <= {CW{1'b0}};
         acc_r       <= {OW{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         acc_r       <= acc_nxt_s;
         in_ready_r  <= (state_nxt_s == ST_ACC);
         out_valid_r <= (state_nxt_s == ST_OUT);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = acc_r;
   assign in_idx    = cnt_r;

endmodule
